// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK levels and R/W bit values.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_RX       = 3'd3,
    ST_RX_ACK   = 3'd4,
    ST_TX       = 3'd5,
    ST_TX_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [7:0] GEN_CALL_WRITE = 8'h00;

endpackage

// File: rtl/i2c_slave_if.sv
// Split-SDA I2C bus: master drives sclk and sda_in, target drives sda_out (1 = released).
interface i2c_slave_if;

  logic sclk;
  logic sda_in;
  logic sda_out;

  modport master (output sclk, output sda_in, input sda_out);
  modport slave  (input sclk, input sda_in, output sda_out);

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises sclk/sda into clk and flags sclk rise/fall plus START/STOP conditions.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic sda,
    output logic scl_level,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_prev;
    logic                   sda_prev;

    // Released-bus level (1) on reset so no spurious edge is seen afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_ff   <= '1;
            sda_ff   <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_ff   <= {scl_ff[SYNC_STAGES-2:0], sclk};
            sda_ff   <= {sda_ff[SYNC_STAGES-2:0], sda};
            scl_prev <= scl_ff[SYNC_STAGES-1];
            sda_prev <= sda_ff[SYNC_STAGES-1];
        end
    end

    assign scl_level = scl_ff[SYNC_STAGES-1];
    assign sda_level = sda_ff[SYNC_STAGES-1];
    assign scl_rise  = scl_level & ~scl_prev;
    assign scl_fall  = ~scl_level & scl_prev;
    assign start_det = scl_level & sda_prev & ~sda_level;
    assign stop_det  = scl_level & ~sda_prev & sda_level;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address decode, ACK generation, byte receive and transmit until STOP.
// Define I2C_SLAVE_GEN_CALL_EN to also accept the general-call write address (8'h00).
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    i2c_slave_if.slave        bus,
    input  logic [7:0]        tx_data,
    output logic              tx_req,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic              addr_hit,
    output logic [2:0]        state
);

    logic scl_level, sda_level, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (bus.sclk),
        .sda       (bus.sda_in),
        .scl_level (scl_level),
        .sda_level (sda_level),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_t st_q, st_d;
    logic [2:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic [7:0] sh_q, sh_d;
    logic       sda_q, sda_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       hit_q, hit_d;
    logic       addr_match;

`ifdef I2C_SLAVE_GEN_CALL_EN
    assign addr_match = (sh_q[7:1] == SLAVE_ADDR) || (sh_q == GEN_CALL_WRITE);
`else
    assign addr_match = (sh_q[7:1] == SLAVE_ADDR);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q       <= ST_IDLE;
            cnt_q      <= 3'd0;
            done_q     <= 1'b0;
            sh_q       <= 8'h00;
            sda_q      <= 1'b1;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            sh_q       <= sh_d;
            sda_q      <= sda_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            hit_q      <= hit_d;
        end
    end

    // done_q marks that the 8th rise of the current byte (or a master ACK) has been seen;
    // the action for it is taken on the following sclk fall.
    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        sh_d       = sh_q;
        sda_d      = sda_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        hit_d      = hit_q;
        if (stop_det) begin
            st_d   = ST_IDLE;
            sda_d  = 1'b1;
            hit_d  = 1'b0;
            cnt_d  = 3'd0;
            done_d = 1'b0;
        end else if (start_det) begin
            st_d   = ST_ADDR;
            sda_d  = 1'b1;
            hit_d  = 1'b0;
            cnt_d  = 3'd0;
            done_d = 1'b0;
        end else begin
            case (st_q)
                ST_IDLE: sda_d = 1'b1;
                ST_ADDR, ST_RX: begin
                    if (scl_rise) begin
                        sh_d   = {sh_q[6:0], sda_level};
                        cnt_d  = cnt_q + 3'd1;
                        done_d = (cnt_q == 3'd7);
                    end else if (scl_fall && done_q) begin
                        done_d = 1'b0;
                        cnt_d  = 3'd0;
                        if (st_q == ST_RX) begin
                            rx_data_d  = sh_q;
                            rx_valid_d = 1'b1;
                            sda_d      = I2C_ACK;
                            st_d       = ST_RX_ACK;
                        end else if (addr_match) begin
                            sda_d = I2C_ACK;
                            hit_d = 1'b1;
                            st_d  = ST_ADDR_ACK;
                        end else begin
                            st_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d  = 3'd0;
                        done_d = 1'b0;
                        if (sh_q[0] == RW_READ) begin
                            sh_d     = tx_data;
                            tx_req_d = 1'b1;
                            sda_d    = tx_data[7];
                            st_d     = ST_TX;
                        end else begin
                            sda_d = 1'b1;
                            st_d  = ST_RX;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_d = 1'b1;
                        st_d  = ST_RX;
                    end
                end
                ST_TX: begin
                    if (scl_rise) begin
                        cnt_d  = cnt_q + 3'd1;
                        done_d = (cnt_q == 3'd7);
                    end else if (scl_fall) begin
                        if (done_q) begin
                            done_d = 1'b0;
                            sda_d  = 1'b1;
                            st_d   = ST_TX_ACK;
                        end else begin
                            sh_d  = {sh_q[6:0], 1'b0};
                            sda_d = sh_q[6];
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_level == I2C_ACK) done_d = 1'b1;
                        else                      st_d   = ST_IGNORE;
                    end else if (scl_fall && done_q) begin
                        done_d   = 1'b0;
                        cnt_d    = 3'd0;
                        sh_d     = tx_data;
                        tx_req_d = 1'b1;
                        sda_d    = tx_data[7];
                        st_d     = ST_TX;
                    end
                end
                ST_IGNORE: sda_d = 1'b1;
                default: begin
                    st_d  = ST_IDLE;
                    sda_d = 1'b1;
                end
            endcase
        end
    end

    assign bus.sda_out = sda_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_req      = tx_req_q;
    assign addr_hit    = hit_q;
    assign state       = st_q;

endmodule
